// File: rtl/mic_vol_meter.sv
// Peak-hold microphone volume meter producing a 4-bit level per window.
// Optional release-limited output: define VOL_METER_DECAY_EN.
module mic_vol_meter #(
  parameter int unsigned WINDOW = 4000,
  parameter int unsigned FLOOR  = 2048,
  parameter int unsigned SHIFT  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  output logic [3:0]  vol_lvl,
  output logic        vol_valid,
  output logic [11:0] peak_out
);

  typedef enum logic {
    ACC = 1'b0,
    MAP = 1'b1
  } state_e;

  localparam logic [15:0] LAST    = 16'(WINDOW - 1);
  localparam logic [12:0] FLOOR13 = 13'(FLOOR);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] run_q, run_d;
  logic [11:0] win_q, win_d;
  logic [3:0]  lvl_q, lvl_d;
  logic        vld_q, vld_d;
  logic [11:0] pk_q, pk_d;

  logic        win_end;
  logic [11:0] run_max;
  logic [12:0] diff;
  logic [12:0] shifted;
  logic [3:0]  lvl_new;
  logic [3:0]  lvl_out;

  assign run_max = (mic_in > run_q) ? mic_in : run_q;
  assign win_end = (state_q == ACC) && sample_valid
                && (cnt_q == LAST);

  // Quantise the captured window peak to a 0..15 level
  always_comb begin
    diff    = {1'b0, win_q} - FLOOR13;
    shifted = diff >> SHIFT;
    lvl_new = 4'd0;
    if ({1'b0, win_q} <= FLOOR13) begin
      lvl_new = 4'd0;
    end else if (shifted > 13'd15) begin
      lvl_new = 4'd15;
    end else begin
      lvl_new = shifted[3:0];
    end
  end

  // Choose what the displayed level becomes this window
  always_comb begin
`ifdef VOL_METER_DECAY_EN
    if (lvl_new >= lvl_q) begin
      lvl_out = lvl_new;
    end else begin
      lvl_out = lvl_q - 4'd1;
    end
`else
    lvl_out = lvl_new;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: MAP lasts exactly one cycle after a window closes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC: if (win_end) state_d = MAP;
      MAP: state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Sample accumulation; a strobe in MAP seeds the next window
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    win_d = win_q;
    unique case (state_q)
      ACC: begin
        if (sample_valid) begin
          if (cnt_q == LAST) begin
            win_d = run_max;
            cnt_d = 16'd0;
            run_d = 12'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
            run_d = run_max;
          end
        end
      end
      MAP: begin
        if (sample_valid) begin
          cnt_d = 16'd1;
          run_d = mic_in;
        end
      end
      default: begin
        cnt_d = cnt_q;
        run_d = run_q;
      end
    endcase
  end

  // Output update: level, peak and strobe land on the MAP edge
  always_comb begin
    lvl_d = lvl_q;
    pk_d  = pk_q;
    vld_d = 1'b0;
    if (state_q == MAP) begin
      lvl_d = lvl_out;
      pk_d  = win_q;
      vld_d = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
      run_q <= 12'd0;
      win_q <= 12'd0;
      lvl_q <= 4'd0;
      vld_q <= 1'b0;
      pk_q  <= 12'd0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      win_q <= win_d;
      lvl_q <= lvl_d;
      vld_q <= vld_d;
      pk_q  <= pk_d;
    end
  end

  assign vol_lvl   = lvl_q;
  assign vol_valid = vld_q;
  assign peak_out  = pk_q;

endmodule

// File: tb/tb_mic_vol_meter.sv
// Directed self-checking bench for mic_vol_meter (WINDOW=8).
// Define VOL_METER_DECAY_EN to also run the release-limited test.
module tb_mic_vol_meter;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [3:0]  vol_lvl;
  logic        vol_valid;
  logic [11:0] peak_out;

  int n_chk;
  int n_pass;
  int vv_cnt;

  mic_vol_meter #(
    .WINDOW(8),
    .FLOOR (2048),
    .SHIFT (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .mic_in      (mic_in),
    .vol_lvl     (vol_lvl),
    .vol_valid   (vol_valid),
    .peak_out    (peak_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (vol_valid === 1'b1) vv_cnt++;

  // Idle mic_in is driven to full scale to prove it is ignored.
  task automatic send(input logic [11:0] v, input int gap);
    sample_valid = 1'b1;
    mic_in = v;
    @(negedge clk);
    sample_valid = 1'b0;
    mic_in = 12'hFFF;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_n(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) send(v, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called right after the window's last sample was accepted.
  task automatic expect_win(input string nm, input logic [3:0] el,
                            input logic [11:0] ep);
    n_chk++;
    if (vol_valid !== 1'b0)
      $display("FAIL %s early_valid got=%0b want=0", nm, vol_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (vol_valid !== 1'b1)
      $display("FAIL %s valid got=%0b want=1", nm, vol_valid);
    else n_pass++;
    n_chk++;
    if (vol_lvl !== el)
      $display("FAIL %s lvl got=%0d want=%0d", nm, vol_lvl, el);
    else n_pass++;
    n_chk++;
    if (peak_out !== ep)
      $display("FAIL %s peak got=%0d want=%0d", nm, peak_out, ep);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (vol_valid !== 1'b0)
      $display("FAIL %s valid_drop got=%0b want=0", nm, vol_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b1;
    sample_valid = 1'b0;
    mic_in = 12'hFFF;
    #2;
    n_chk++;
    if ({vol_lvl, vol_valid, peak_out} !== 17'd0)
      $display("FAIL rst_init got=%h want=0",
               {vol_lvl, vol_valid, peak_out});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    send_n(12'd4095, 8);
    expect_win("rst_pre", 4'd15, 12'd4095);
    send_n(12'd4095, 5);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({vol_lvl, vol_valid, peak_out} !== 17'd0)
      $display("FAIL rst_async got=%h want=0",
               {vol_lvl, vol_valid, peak_out});
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1 base = vv_cnt;
    @(negedge clk);
    send_n(12'd2048, 7);
    #1;
    n_chk++;
    if (vv_cnt != base)
      $display("FAIL rst_partial pulses got=%0d want=0", vv_cnt - base);
    else n_pass++;
    send(12'd2048, 0);
    expect_win("rst_post", 4'd0, 12'd2048);
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (vv_cnt - base != 1)
      $display("FAIL rst_pulses got=%0d want=1", vv_cnt - base);
    else n_pass++;
  endtask

  task automatic test_quant();
    do_reset();
    send_n(12'd2000, 7);
    send(12'd2688, 0);
    expect_win("quant5", 4'd5, 12'd2688);
  endtask

  task automatic test_boundary();
    do_reset();
    send_n(12'd2175, 8);
    expect_win("bnd_2175", 4'd0, 12'd2175);
    send_n(12'd2176, 8);
    expect_win("bnd_2176", 4'd1, 12'd2176);
    send_n(12'd2049, 8);
`ifdef VOL_METER_DECAY_EN
    expect_win("bnd_2049", 4'd0, 12'd2049);
`else
    expect_win("bnd_2049", 4'd0, 12'd2049);
`endif
  endtask

  task automatic test_sat_floor();
    do_reset();
    send_n(12'd4095, 8);
    expect_win("sat", 4'd15, 12'd4095);
    send_n(12'd1000, 8);
`ifdef VOL_METER_DECAY_EN
    expect_win("floor", 4'd14, 12'd1000);
`else
    expect_win("floor", 4'd0, 12'd1000);
`endif
  endtask

  task automatic test_gapped();
    int base;
    logic [11:0] v;
    do_reset();
    #1 base = vv_cnt;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      v = (i == 3) ? 12'd2300 : 12'd2100;
      send(v, (i % 3) + 1);
    end
    repeat (5) @(negedge clk);
    #1;
    n_chk++;
    if (vv_cnt != base)
      $display("FAIL gap_early pulses got=%0d want=0", vv_cnt - base);
    else n_pass++;
    @(negedge clk);
    send(12'd2442, 0);
    expect_win("gap8", 4'd3, 12'd2442);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_n(12'd2048, 8);
    send(12'd4095, 0);
    n_chk++;
    if (vol_valid !== 1'b1 || vol_lvl !== 4'd0)
      $display("FAIL b2b_first got=%0b/%0d want=1/0",
               vol_valid, vol_lvl);
    else n_pass++;
    send_n(12'd2048, 7);
    expect_win("b2b_next", 4'd15, 12'd4095);
  endtask

`ifdef VOL_METER_DECAY_EN
  task automatic test_decay();
    do_reset();
    send_n(12'd4095, 8);
    expect_win("dec15", 4'd15, 12'd4095);
    send_n(12'd2048, 8);
    expect_win("dec14", 4'd14, 12'd2048);
    send_n(12'd2048, 8);
    expect_win("dec13", 4'd13, 12'd2048);
    send_n(12'd2048, 8);
    expect_win("dec12", 4'd12, 12'd2048);
    send_n(12'd2688, 8);
    expect_win("dec11", 4'd11, 12'd2688);
    send_n(12'd4095, 8);
    expect_win("dec_atk", 4'd15, 12'd4095);
  endtask
`endif

  task automatic test_idle();
    int base;
    logic [3:0] held;
    do_reset();
    send_n(12'd2688, 8);
    expect_win("idle_pre", 4'd5, 12'd2688);
    #1 base = vv_cnt;
    held = 4'd5;
    repeat (100) @(negedge clk);
    #1;
    n_chk++;
    if (vv_cnt != base)
      $display("FAIL idle_pulses got=%0d want=0", vv_cnt - base);
    else n_pass++;
    n_chk++;
    if (vol_lvl !== held)
      $display("FAIL idle_hold got=%0d want=%0d", vol_lvl, held);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    vv_cnt = 0;
    test_reset();
    test_quant();
    test_boundary();
    test_sat_floor();
    test_gapped();
    test_back_to_back();
`ifdef VOL_METER_DECAY_EN
    test_decay();
`endif
    test_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
